spram_be: RTL and testbench
===========================

SPRAM_BE -- requirements
Module: spram_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, meaning bits per write-enable lane; DATA_WIDTH SHALL be an integer multiple of it, and NB = DATA_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter RAM_DEPTH, default 16, meaning number of words (any value >= 2, not restricted to a power of 2).
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(RAM_DEPTH), meaning address width.
REQ-005 SHALL have parameter WRITE_MODE, default 0, meaning 0 = write-first, 1 = read-first, 2 = no-change.
REQ-006 SHALL have parameter OUT_REG, default 0, meaning 0 = read latency 1, 1 = read latency 2 (extra output register).
REQ-007 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit, meaning reset, synchronous, active-low.
REQ-009 SHALL have port ena, input, 1 bit, meaning access request for this cycle.
REQ-010 SHALL have port wea, input, NB bits, meaning per-lane write enable; wea == 0 with ena = 1 is a read.
REQ-011 SHALL have port addra, input, ADDR_WIDTH bits, meaning word address.
REQ-012 SHALL have port dina, input, DATA_WIDTH bits, meaning write data.
REQ-013 SHALL have port douta, output, DATA_WIDTH bits, meaning read data.
REQ-014 SHALL have port dout_vld, output, 1 bit, meaning a one-cycle strobe that douta carries the result of an access.
REQ-015 SHALL have port init_busy, output, 1 bit, meaning the clear sequence is running and accesses are ignored.

Function
REQ-016 SHALL implement a 2-state FSM, CLEAR and READY; the reset state is CLEAR, with clear counter = 0.
REQ-017 In CLEAR, SHALL write all-zero to address = counter each cycle and increment the counter; after writing address RAM_DEPTH-1, SHALL enter READY on the next edge, so the clear takes exactly RAM_DEPTH cycles after rst_n deasserts.
REQ-018 init_busy SHALL be 1 exactly while the state is CLEAR; in CLEAR, ena/wea SHALL be ignored: no user write, no dout_vld.
REQ-019 In READY, an access with ena = 1 and any wea bit set SHALL write dina to lanes whose wea bit is 1; other lanes keep their old bytes.
REQ-020 For a read (ena = 1, wea = 0), douta SHALL show mem[addra] with dout_vld = 1 exactly 1 cycle (OUT_REG = 0) or 2 cycles (OUT_REG = 1) after the access edge.
REQ-021 For a write with WRITE_MODE = 0, SHALL return the merged new word (new lanes plus untouched old lanes) with dout_vld at read latency.
REQ-022 For a write with WRITE_MODE = 1, SHALL return the pre-write word with dout_vld at read latency.
REQ-023 For a write with WRITE_MODE = 2, SHALL leave douta unchanged and SHALL NOT assert dout_vld.
REQ-024 douta SHALL hold its last value whenever no result is delivered (ena = 0, no-change writes, CLEAR).
REQ-025 Accesses SHALL be fully pipelined: one per cycle, back-to-back, with no stall.
REQ-026 A read of an address written in the immediately preceding cycle SHALL return the newly written data.
REQ-027 addra >= RAM_DEPTH: writes SHALL be dropped, and reads or writes SHALL return 0 with dout_vld still asserted per mode.

Reset
REQ-028 On any edge with rst_n = 0, SHALL set: state = CLEAR, counter = 0, douta = 0, dout_vld = 0, init_busy = 1, all pipeline valid bits = 0.
REQ-029 rst_n asserted mid-CLEAR or mid-pipeline SHALL restart the clear from address 0 and drop all in-flight results (no dout_vld for them).
REQ-030 Reset SHALL NOT itself alter memory; zeroing happens only via the CLEAR sequence.

Verification
REQ-031 Reset release with RAM_DEPTH = 16: init_busy = 1 for exactly 16 cycles, then 0; a read of every address returns 0.
REQ-032 OUT_REG = 0, write 0xDEADBEEF to addr 3, then read addr 3 on the next cycle: douta = 0xDEADBEEF with dout_vld 1 cycle after the read edge; with OUT_REG = 1, 2 cycles after.
REQ-033 addr 5 = 0x11223344, write 0xAABBCCDD with wea = 4'b0101: WRITE_MODE 0 returns 0x11BB33DD, mode 1 returns 0x11223344, mode 2 gives no dout_vld and holds douta; a later read returns 0x11BB33DD in all modes.
REQ-034 Reads of addr 0..15 on 16 consecutive cycles produce 16 consecutive dout_vld pulses, in order, with correct data.
REQ-035 rst_n pulsed low at clear counter = 7, with a read in flight: no dout_vld for the in-flight read, and init_busy stays 1 for 16 further cycles after release.
REQ-036 RAM_DEPTH = 12: write to addr 13 leaves all words unchanged; a read of addr 13 returns 0 with dout_vld = 1.

Source files
------------

// File: rtl/spram_be.sv
// Single-port RAM with per-lane write enables, selectable write mode and
// read latency, and a self-clearing sequence that zeroes every word after reset.
module spram_be #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int RAM_DEPTH  = 16,
   parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
   parameter int WRITE_MODE = 0,
   parameter int OUT_REG    = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             ena,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
   input  logic [ADDR_WIDTH-1:0]            addra,
   input  logic [DATA_WIDTH-1:0]            dina,
   output logic [DATA_WIDTH-1:0]            douta,
   output logic                             dout_vld,
   output logic                             init_busy
);

   localparam int NB = DATA_WIDTH / BYTE_WIDTH;

   typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic                  r_busy;

   logic                  w_acc;
   logic                  w_wr;
   logic                  w_in_rng;
   logic [DATA_WIDTH-1:0] w_old;
   logic [DATA_WIDTH-1:0] w_merged;
   logic                  w_res_vld;
   logic [DATA_WIDTH-1:0] w_res_data;

   logic                  r_p1_vld;
   logic [DATA_WIDTH-1:0] r_p1_data;

   // State, clear counter and busy flag registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_CLEAR;
         r_cnt   <= {ADDR_WIDTH{1'b0}};
         r_busy  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == S_CLEAR);
      end
   end

   // Next-state logic: walk the counter across the array, then go ready
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_CLEAR: begin
            if (r_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
               w_state_nxt = S_READY;
               w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
            end else begin
               w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
            end
         end
         S_READY: begin
            w_state_nxt = S_READY;
         end
         default: begin
            w_state_nxt = S_CLEAR;
            w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   // Access decode: lane merge and the result word for the selected write mode
   always_comb begin
      w_acc      = (r_state == S_READY) && ena;
      w_wr       = w_acc && (|wea);
      w_in_rng   = ({1'b0, addra} < (ADDR_WIDTH + 1)'(RAM_DEPTH));
      w_old      = {DATA_WIDTH{1'b0}};
      w_merged   = {DATA_WIDTH{1'b0}};
      w_res_vld  = 1'b0;
      w_res_data = {DATA_WIDTH{1'b0}};
      if (w_in_rng) begin
         w_old = r_mem[addra];
      end else begin
         w_old = {DATA_WIDTH{1'b0}};
      end
      for (int l = 0; l < NB; l++) begin
         if (wea[l]) begin
            w_merged[l*BYTE_WIDTH +: BYTE_WIDTH] = dina[l*BYTE_WIDTH +: BYTE_WIDTH];
         end else begin
            w_merged[l*BYTE_WIDTH +: BYTE_WIDTH] = w_old[l*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      if (!w_acc) begin
         w_res_vld = 1'b0;
      end else if (!w_wr) begin
         w_res_vld  = 1'b1;
         w_res_data = w_old;
      end else begin
         // Out-of-range writes are dropped and report zero
         w_res_vld  = (WRITE_MODE != 2);
         w_res_data = (WRITE_MODE == 1 || !w_in_rng) ? w_old : w_merged;
      end
   end

   // Memory array: zeroing during clear, lane-merged user writes when ready
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= {DATA_WIDTH{1'b0}};
         end else if (w_wr && w_in_rng) begin
            r_mem[addra] <= w_merged;
         end
      end
   end

   // First output stage: data only updates when a result is delivered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_p1_vld  <= 1'b0;
         r_p1_data <= {DATA_WIDTH{1'b0}};
      end else begin
         r_p1_vld <= w_res_vld;
         if (w_res_vld) begin
            r_p1_data <= w_res_data;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  r_p2_vld;
         logic [DATA_WIDTH-1:0] r_p2_data;

         // Optional second output stage, holding data between results
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_p2_vld  <= 1'b0;
               r_p2_data <= {DATA_WIDTH{1'b0}};
            end else begin
               r_p2_vld <= r_p1_vld;
               if (r_p1_vld) begin
                  r_p2_data <= r_p1_data;
               end
            end
         end

         assign douta    = r_p2_data;
         assign dout_vld = r_p2_vld;
      end else begin : g_no_out_reg
         assign douta    = r_p1_data;
         assign dout_vld = r_p1_vld;
      end
   endgenerate

   assign init_busy = r_busy;

endmodule

// File: tb/tb_spram_be.sv
// Directed bench: four spram_be variants share one stimulus stream.
//   d0: write-first, latency 1     d1: read-first, latency 2
//   d2: no-change,   latency 1     d3: write-first, latency 1, 12 words
module tb_spram_be;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [3:0]  wea;
   logic [3:0]  addra;
   logic [31:0] dina;
   logic [31:0] dout [4];
   logic        vld  [4];
   logic        busy [4];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spram_be #(.WRITE_MODE(0), .OUT_REG(0)) u_d0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout[0]), .dout_vld(vld[0]), .init_busy(busy[0]));
   spram_be #(.WRITE_MODE(1), .OUT_REG(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout[1]), .dout_vld(vld[1]), .init_busy(busy[1]));
   spram_be #(.WRITE_MODE(2), .OUT_REG(0)) u_d2 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout[2]), .dout_vld(vld[2]), .init_busy(busy[2]));
   spram_be #(.WRITE_MODE(0), .OUT_REG(0), .RAM_DEPTH(12)) u_d3 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout[3]), .dout_vld(vld[3]), .init_busy(busy[3]));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_acc(input logic e, input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
      ena   = e;
      wea   = we;
      addra = a;
      dina  = d;
   endtask

   // Called with rst_n just released: counts busy samples while hammering
   // the inputs with writes that must be ignored.
   task automatic clear_wait(input string tag);
      int nb [4];
      int nv;
      nv = 0;
      for (int d = 0; d < 4; d++) nb[d] = 0;
      for (int k = 0; k < 20; k++) begin
         for (int d = 0; d < 4; d++) begin
            if (busy[d]) nb[d]++;
            if (vld[d]) nv++;
         end
         if (k < 12) set_acc(1'b1, 4'hF, 4'(k), 32'hFFFF_FFFF);
         else        set_acc(1'b0, 4'h0, 4'h0, 32'h0);
         step();
      end
      check_eq({tag, " busy_cycles d0"}, 32'(nb[0]), 32'd16);
      check_eq({tag, " busy_cycles d1"}, 32'(nb[1]), 32'd16);
      check_eq({tag, " busy_cycles d2"}, 32'(nb[2]), 32'd16);
      check_eq({tag, " busy_cycles d3"}, 32'(nb[3]), 32'd12);
      check_eq({tag, " vld_during_clear"}, 32'(nv), 32'd0);
      check_eq({tag, " busy_after d0"}, 32'(busy[0]), 32'd0);
      check_eq({tag, " busy_after d3"}, 32'(busy[3]), 32'd0);
   endtask

   // ph 0: read all (expect 0), ph 1: write pat(i) everywhere, ph 2: read pat back
   task automatic sweep(input int ph);
      logic [31:0] e_mem;
      logic [31:0] e_prev;
      for (int i = 0; i < 18; i++) begin
         if (i < 16) set_acc(1'b1, (ph == 1) ? 4'hF : 4'h0, 4'(i), pat(i));
         else        set_acc(1'b0, 4'h0, 4'h0, 32'h0);
         step();
         if (i < 16) begin
            e_mem = (ph == 2) ? pat(i) : 32'h0;
            check_eq($sformatf("sw%0d d0 vld a%0d", ph, i), 32'(vld[0]), 32'd1);
            check_eq($sformatf("sw%0d d0 dout a%0d", ph, i), dout[0], (ph == 1) ? pat(i) : e_mem);
            check_eq($sformatf("sw%0d d2 vld a%0d", ph, i), 32'(vld[2]), (ph == 1) ? 32'd0 : 32'd1);
            check_eq($sformatf("sw%0d d2 dout a%0d", ph, i), dout[2], (ph == 1) ? 32'h0 : e_mem);
            check_eq($sformatf("sw%0d d3 vld a%0d", ph, i), 32'(vld[3]), 32'd1);
            check_eq($sformatf("sw%0d d3 dout a%0d", ph, i), dout[3],
                     (i >= 12) ? 32'h0 : ((ph == 1) ? pat(i) : e_mem));
         end else begin
            check_eq($sformatf("sw%0d d0 idle vld %0d", ph, i), 32'(vld[0]), 32'd0);
            check_eq($sformatf("sw%0d d0 hold %0d", ph, i), dout[0], (ph == 0) ? 32'h0 : pat(15));
            check_eq($sformatf("sw%0d d3 idle vld %0d", ph, i), 32'(vld[3]), 32'd0);
         end
         if (i >= 1 && i < 17) begin
            e_prev = (ph == 2) ? pat(i - 1) : 32'h0;
            check_eq($sformatf("sw%0d d1 vld a%0d", ph, i - 1), 32'(vld[1]), 32'd1);
            check_eq($sformatf("sw%0d d1 dout a%0d", ph, i - 1), dout[1], e_prev);
         end else begin
            check_eq($sformatf("sw%0d d1 idle vld %0d", ph, i), 32'(vld[1]), 32'd0);
         end
      end
   endtask

   initial begin
      int nv1;
      rst_n = 1'b0;
      set_acc(1'b0, 4'h0, 4'h0, 32'h0);
      repeat (3) step();

      // Reset state
      check_eq("rst d0 dout", dout[0], 32'h0);
      check_eq("rst d0 vld", 32'(vld[0]), 32'd0);
      check_eq("rst d0 busy", 32'(busy[0]), 32'd1);
      check_eq("rst d1 dout", dout[1], 32'h0);
      check_eq("rst d1 vld", 32'(vld[1]), 32'd0);
      check_eq("rst d3 busy", 32'(busy[3]), 32'd1);

      rst_n = 1'b1;
      clear_wait("clr1");

      sweep(0);
      sweep(1);
      sweep(2);

      // Write then read the same address on the next cycle
      set_acc(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF);
      step();
      check_eq("raw wr d0 vld", 32'(vld[0]), 32'd1);
      check_eq("raw wr d0 dout", dout[0], 32'hDEAD_BEEF);
      check_eq("raw wr d2 vld", 32'(vld[2]), 32'd0);
      check_eq("raw wr d2 hold", dout[2], pat(15));
      check_eq("raw wr d1 vld", 32'(vld[1]), 32'd0);
      set_acc(1'b1, 4'h0, 4'd3, 32'h0);
      step();
      check_eq("raw rd d0 dout", dout[0], 32'hDEAD_BEEF);
      check_eq("raw rd d2 vld", 32'(vld[2]), 32'd1);
      check_eq("raw rd d2 dout", dout[2], 32'hDEAD_BEEF);
      check_eq("raw rd d3 dout", dout[3], 32'hDEAD_BEEF);
      check_eq("raw wr d1 vld", 32'(vld[1]), 32'd1);
      check_eq("raw wr d1 old", dout[1], pat(3));
      set_acc(1'b0, 4'h0, 4'h0, 32'h0);
      step();
      check_eq("raw rd d1 vld", 32'(vld[1]), 32'd1);
      check_eq("raw rd d1 dout", dout[1], 32'hDEAD_BEEF);
      check_eq("raw idle d0 vld", 32'(vld[0]), 32'd0);
      check_eq("raw idle d0 hold", dout[0], 32'hDEAD_BEEF);
      step();
      check_eq("raw idle d1 vld", 32'(vld[1]), 32'd0);

      // Partial-lane write over a known word
      set_acc(1'b1, 4'hF, 4'd5, 32'h1122_3344);
      step();
      set_acc(1'b0, 4'h0, 4'h0, 32'h0);
      step();
      check_eq("be idle d0 vld", 32'(vld[0]), 32'd0);
      check_eq("be idle d0 hold", dout[0], 32'h1122_3344);
      check_eq("be idle d2 hold", dout[2], 32'hDEAD_BEEF);
      check_eq("be pre d1 old", dout[1], pat(5));
      set_acc(1'b1, 4'b0101, 4'd5, 32'hAABB_CCDD);
      step();
      check_eq("be wr d0 vld", 32'(vld[0]), 32'd1);
      check_eq("be wr d0 merged", dout[0], 32'h11BB_33DD);
      check_eq("be wr d3 merged", dout[3], 32'h11BB_33DD);
      check_eq("be wr d2 vld", 32'(vld[2]), 32'd0);
      check_eq("be wr d2 hold", dout[2], 32'hDEAD_BEEF);
      check_eq("be wr d1 vld", 32'(vld[1]), 32'd0);
      set_acc(1'b1, 4'h0, 4'd5, 32'h0);
      step();
      check_eq("be rd d0 dout", dout[0], 32'h11BB_33DD);
      check_eq("be rd d2 vld", 32'(vld[2]), 32'd1);
      check_eq("be rd d2 dout", dout[2], 32'h11BB_33DD);
      check_eq("be wr d1 vld", 32'(vld[1]), 32'd1);
      check_eq("be wr d1 old", dout[1], 32'h1122_3344);
      set_acc(1'b0, 4'h0, 4'h0, 32'h0);
      step();
      check_eq("be rd d1 vld", 32'(vld[1]), 32'd1);
      check_eq("be rd d1 dout", dout[1], 32'h11BB_33DD);

      // Reset with a latency-2 read in flight, then again mid-clear
      set_acc(1'b1, 4'h0, 4'd5, 32'h0);
      step();
      check_eq("inflight d0 dout", dout[0], 32'h11BB_33DD);
      set_acc(1'b0, 4'h0, 4'h0, 32'h0);
      rst_n = 1'b0;
      step();
      check_eq("rst2 d1 vld", 32'(vld[1]), 32'd0);
      check_eq("rst2 d1 dout", dout[1], 32'h0);
      check_eq("rst2 d0 vld", 32'(vld[0]), 32'd0);
      check_eq("rst2 d0 dout", dout[0], 32'h0);
      check_eq("rst2 d0 busy", 32'(busy[0]), 32'd1);
      rst_n = 1'b1;
      nv1 = 0;
      for (int k = 0; k < 7; k++) begin
         step();
         if (vld[1]) nv1++;
      end
      check_eq("inflight d1 no vld", 32'(nv1), 32'd0);
      check_eq("midclr d0 busy", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      clear_wait("clr2");
      sweep(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
